// File: rtl/toy_exec_pkg.sv
// Shared definitions for the toy execution unit: opcodes, branch conditions,
// FSM state constants and the branch-condition helper.
package toy_exec_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_ADDI = 5'd1,
    OP_SUB  = 5'd2,
    OP_NEG  = 5'd3,
    OP_NOT  = 5'd4,
    OP_AND  = 5'd5,
    OP_ANDI = 5'd6,
    OP_OR   = 5'd7,
    OP_ORI  = 5'd8,
    OP_XOR  = 5'd9,
    OP_MOVI = 5'd10,
    OP_LSR  = 5'd11,
    OP_ASR  = 5'd12,
    OP_SHL  = 5'd13,
    OP_ROR  = 5'd14,
    OP_MUL  = 5'd15,
    OP_BR   = 5'd16,
    OP_BRL  = 5'd17,
    OP_J    = 5'd18,
    OP_JL   = 5'd19,
    OP_LD   = 5'd20,
    OP_ST   = 5'd21,
    OP_LDR  = 5'd22,
    OP_STR  = 5'd23
  } op_e;

  localparam logic [2:0] CC_NEVER  = 3'd0;
  localparam logic [2:0] CC_ALWAYS = 3'd1;
  localparam logic [2:0] CC_EQZ    = 3'd2;
  localparam logic [2:0] CC_NEZ    = 3'd3;
  localparam logic [2:0] CC_GEZ    = 3'd4;
  localparam logic [2:0] CC_LTZ    = 3'd5;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  // Codes 6 and 7 are reserved and never redirect.
  function automatic logic condMet(input logic [2:0] cond, input logic bZero, input logic bNeg);
    logic met;
    case (cond)
      CC_ALWAYS: met = 1'b1;
      CC_EQZ:    met = bZero;
      CC_NEZ:    met = !bZero;
      CC_GEZ:    met = !bNeg;
      CC_LTZ:    met = bNeg;
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/toy_iter_mul.sv
// Shift-add multiplier retiring one multiplier bit per cycle; done_o pulses
// on the final iteration with the low XW bits of the product on result_o.
module toy_iter_mul
  import toy_exec_pkg::*;
#(
  parameter int XW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [XW-1:0] a_i,
  input  logic [XW-1:0] b_i,
  output logic          done_o,
  output logic [XW-1:0] result_o
);

  localparam int CW = $clog2(XW) + 1;

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] acc_q, acc_d;
  logic [XW-1:0] mcand_q, mcand_d;
  logic [XW-1:0] mplier_q, mplier_d;
  logic [XW-1:0] accStep;

  // The last partial sum is presented combinationally so the caller can
  // capture it on the same edge that retires the final bit.
  assign accStep  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o   = busy_q && (cnt_q == CW'(XW - 1));
  assign result_o = accStep;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (abort_i) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = a_i;
      mplier_d = b_i;
    end else if (busy_q) begin
      acc_d    = accStep;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/toy_exec_unit.sv
// Toy execution unit: single-cycle ALU/branch/address ops plus an iterative
// multiply, with a valid/ready input port and a registered output stage.
module toy_exec_unit
  import toy_exec_pkg::*;
#(
  parameter int XW     = 32,
  parameter int MUL_EN = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inValid_i,
  output logic          inReady_o,
  input  logic [4:0]    inOp_i,
  input  logic [2:0]    inCond_i,
  input  logic [XW-1:0] inA_i,
  input  logic [XW-1:0] inB_i,
  input  logic [XW-1:0] inImm_i,
  input  logic [XW-1:0] inPc_i,
  input  logic [4:0]    inDest_i,
  input  logic          flush_i,
  output logic          outValid_o,
  input  logic          outReady_i,
  output logic [XW-1:0] outResult_o,
  output logic [4:0]    outDest_o,
  output logic          outWen_o,
  output logic          outIllegal_o,
  output logic          brTaken_o,
  output logic [XW-1:0] brTarget_o
);

  localparam int SHW = $clog2(XW);

  logic [0:0]    state_q, state_d;
  logic          outValid_q, outValid_d;
  logic [XW-1:0] outResult_q, outResult_d;
  logic [4:0]    outDest_q, outDest_d;
  logic          outWen_q, outWen_d;
  logic          outIllegal_q, outIllegal_d;
  logic          brTaken_q, brTaken_d;
  logic [XW-1:0] brTarget_q, brTarget_d;
  logic [4:0]    mulDest_q, mulDest_d;

  logic [SHW-1:0] shAmt;
  logic [XW-1:0]  rorRes;
  logic [XW-1:0]  decResult, decTarget;
  logic           decWen, decIll, decTaken, decIsMul, brMet;
  logic           accept, mulStart, mulDone;
  logic [XW-1:0]  mulResult;

  assign inReady_o = !rst_i && !flush_i && (state_q == ST_IDLE) && (!outValid_q || outReady_i);
  assign accept    = inValid_i && inReady_o;
  assign mulStart  = accept && decIsMul;
  assign shAmt     = inB_i[SHW-1:0];
  assign rorRes    = XW'({inA_i, inA_i} >> shAmt);
  assign brMet     = condMet(inCond_i, inB_i == '0, inB_i[XW-1]);

  // Operation decode for everything that completes in a single cycle.
  always_comb begin
    decResult = '0;
    decTarget = '0;
    decWen    = 1'b0;
    decIll    = 1'b0;
    decTaken  = 1'b0;
    decIsMul  = 1'b0;
    case (inOp_i)
      OP_ADD:  begin decResult = inA_i + inB_i;   decWen = 1'b1; end
      OP_ADDI: begin decResult = inB_i + inImm_i; decWen = 1'b1; end
      OP_SUB:  begin decResult = inA_i - inB_i;   decWen = 1'b1; end
      OP_NEG:  begin decResult = '0 - inB_i;      decWen = 1'b1; end
      OP_NOT:  begin decResult = ~inB_i;          decWen = 1'b1; end
      OP_AND:  begin decResult = inA_i & inB_i;   decWen = 1'b1; end
      OP_ANDI: begin decResult = inB_i & inImm_i; decWen = 1'b1; end
      OP_OR:   begin decResult = inA_i | inB_i;   decWen = 1'b1; end
      OP_ORI:  begin decResult = inB_i | inImm_i; decWen = 1'b1; end
      OP_XOR:  begin decResult = inA_i ^ inB_i;   decWen = 1'b1; end
      OP_MOVI: begin decResult = inImm_i;         decWen = 1'b1; end
      OP_LSR:  begin decResult = inA_i >> shAmt;  decWen = 1'b1; end
      OP_ASR:  begin decResult = $unsigned($signed(inA_i) >>> shAmt); decWen = 1'b1; end
      OP_SHL:  begin decResult = inA_i << shAmt;  decWen = 1'b1; end
      OP_ROR:  begin decResult = rorRes;          decWen = 1'b1; end
      OP_MUL: begin
        if (MUL_EN != 0) begin
          decIsMul = 1'b1;
          decWen   = 1'b1;
        end else begin
          decIll = 1'b1;
        end
      end
      OP_BR:  begin decTaken = brMet; decTarget = inA_i; end
      OP_BRL: begin decTaken = brMet; decTarget = inA_i; decResult = inPc_i; decWen = 1'b1; end
      OP_J:   begin decTaken = 1'b1;  decTarget = inPc_i + inImm_i; end
      OP_JL:  begin decTaken = 1'b1;  decTarget = inPc_i + inImm_i; decResult = inPc_i; decWen = 1'b1; end
      OP_LD:  begin decResult = inB_i + inImm_i;  decWen = 1'b1; end
      OP_ST:  begin decResult = inB_i + inImm_i; end
      OP_LDR: begin decResult = inPc_i + inImm_i; decWen = 1'b1; end
      OP_STR: begin decResult = inPc_i + inImm_i; end
      default: decIll = 1'b1;
    endcase
  end

  toy_iter_mul #(.XW(XW)) uMul (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (mulStart),
    .abort_i  (flush_i),
    .a_i      (inA_i),
    .b_i      (inB_i),
    .done_o   (mulDone),
    .result_o (mulResult)
  );

  // The output stage is empty while a multiply runs, because a multiply is
  // only accepted when the held result is leaving on the same edge.
  always_comb begin
    state_d      = state_q;
    outValid_d   = outValid_q;
    outResult_d  = outResult_q;
    outDest_d    = outDest_q;
    outWen_d     = outWen_q;
    outIllegal_d = outIllegal_q;
    brTaken_d    = brTaken_q;
    brTarget_d   = brTarget_q;
    mulDest_d    = mulDest_q;
    if (flush_i) begin
      state_d    = ST_IDLE;
      outValid_d = 1'b0;
      brTaken_d  = 1'b0;
    end else begin
      if (outValid_q && outReady_i) outValid_d = 1'b0;
      if (accept) begin
        if (decIsMul) begin
          state_d   = ST_MUL_BUSY;
          mulDest_d = inDest_i;
        end else begin
          outValid_d   = 1'b1;
          outResult_d  = decResult;
          outDest_d    = inDest_i;
          outWen_d     = decWen;
          outIllegal_d = decIll;
          brTaken_d    = decTaken;
          brTarget_d   = decTarget;
        end
      end else if ((state_q == ST_MUL_BUSY) && mulDone) begin
        state_d      = ST_IDLE;
        outValid_d   = 1'b1;
        outResult_d  = mulResult;
        outDest_d    = mulDest_q;
        outWen_d     = 1'b1;
        outIllegal_d = 1'b0;
        brTaken_d    = 1'b0;
        brTarget_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      outValid_q   <= 1'b0;
      outResult_q  <= '0;
      outDest_q    <= '0;
      outWen_q     <= 1'b0;
      outIllegal_q <= 1'b0;
      brTaken_q    <= 1'b0;
      brTarget_q   <= '0;
      mulDest_q    <= '0;
    end else begin
      state_q      <= state_d;
      outValid_q   <= outValid_d;
      outResult_q  <= outResult_d;
      outDest_q    <= outDest_d;
      outWen_q     <= outWen_d;
      outIllegal_q <= outIllegal_d;
      brTaken_q    <= brTaken_d;
      brTarget_q   <= brTarget_d;
      mulDest_q    <= mulDest_d;
    end
  end

  assign outValid_o   = outValid_q;
  assign outResult_o  = outResult_q;
  assign outDest_o    = outDest_q;
  assign outWen_o     = outWen_q;
  assign outIllegal_o = outIllegal_q;
  assign brTaken_o    = brTaken_q;
  assign brTarget_o   = brTarget_q;

endmodule

// File: tb/tb_toy_exec_unit.sv
// Bench for toy_exec_unit: a 32-bit unit checked every cycle against a
// transaction-level model, plus a 16-bit unit without MUL checked directly.
module tb_toy_exec_unit;
  import toy_exec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, inValid, outReady;
  logic [4:0]  inOp, inDest;
  logic [2:0]  inCond;
  logic [31:0] inA, inB, inImm, inPc;
  logic        inReady, outValid, outWen, outIllegal, brTaken;
  logic [31:0] outResult, brTarget;
  logic [4:0]  outDest;

  logic        inValid16, outReady16, flush16;
  logic [4:0]  inOp16, inDest16;
  logic [2:0]  inCond16;
  logic [15:0] inA16, inB16, inImm16, inPc16;
  logic        inReady16, outValid16, outWen16, outIllegal16, brTaken16;
  logic [15:0] outResult16, brTarget16;
  logic [4:0]  outDest16;

  int compared = 0;
  int mismatched = 0;

  toy_exec_unit #(.XW(32), .MUL_EN(1)) dut (
    .clk_i(clk), .rst_i(rst), .inValid_i(inValid), .inReady_o(inReady),
    .inOp_i(inOp), .inCond_i(inCond), .inA_i(inA), .inB_i(inB),
    .inImm_i(inImm), .inPc_i(inPc), .inDest_i(inDest), .flush_i(flush),
    .outValid_o(outValid), .outReady_i(outReady), .outResult_o(outResult),
    .outDest_o(outDest), .outWen_o(outWen), .outIllegal_o(outIllegal),
    .brTaken_o(brTaken), .brTarget_o(brTarget)
  );

  toy_exec_unit #(.XW(16), .MUL_EN(0)) dut16 (
    .clk_i(clk), .rst_i(rst), .inValid_i(inValid16), .inReady_o(inReady16),
    .inOp_i(inOp16), .inCond_i(inCond16), .inA_i(inA16), .inB_i(inB16),
    .inImm_i(inImm16), .inPc_i(inPc16), .inDest_i(inDest16), .flush_i(flush16),
    .outValid_o(outValid16), .outReady_i(outReady16), .outResult_o(outResult16),
    .outDest_o(outDest16), .outWen_o(outWen16), .outIllegal_o(outIllegal16),
    .brTaken_o(brTaken16), .brTarget_o(brTarget16)
  );

  typedef struct packed {
    bit [31:0] result;
    bit [31:0] target;
    bit        wen;
    bit        ill;
    bit        taken;
    bit        isMul;
  } expT;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural meaning of one operation on an xw-bit machine.
  function automatic expT modelOp(input int op, input bit [2:0] cond, input bit [31:0] a, b, imm, pc,
                                  input int xw, input bit mulEn);
    expT r;
    bit [63:0] mask, aa, bb, ii, pp, ax, v;
    int sh;
    bit bZero, bNeg, met;
    r = '0;
    mask = (64'd1 << xw) - 64'd1;
    aa = {32'd0, a} & mask;
    bb = {32'd0, b} & mask;
    ii = {32'd0, imm} & mask;
    pp = {32'd0, pc} & mask;
    sh = int'(bb % 64'(xw));
    bZero = (bb == 0);
    bNeg = bb[xw-1];
    case (cond)
      3'd1: met = 1'b1;
      3'd2: met = bZero;
      3'd3: met = !bZero;
      3'd4: met = !bNeg;
      3'd5: met = bNeg;
      default: met = 1'b0;
    endcase
    v = 0;
    r.wen = 1'b1;
    case (op)
      OP_ADD:  v = aa + bb;
      OP_ADDI: v = bb + ii;
      OP_SUB:  v = aa - bb;
      OP_NEG:  v = 64'd0 - bb;
      OP_NOT:  v = ~bb;
      OP_AND:  v = aa & bb;
      OP_ANDI: v = bb & ii;
      OP_OR:   v = aa | bb;
      OP_ORI:  v = bb | ii;
      OP_XOR:  v = aa ^ bb;
      OP_MOVI: v = ii;
      OP_LSR:  v = aa >> sh;
      OP_ASR: begin
        ax = bb[0] ? aa : aa;
        if (aa[xw-1]) ax = aa | ~mask;
        v = ax >> sh;
      end
      OP_SHL:  v = aa << sh;
      OP_ROR:  v = (sh == 0) ? aa : ((aa >> sh) | (aa << (xw - sh)));
      OP_MUL: begin
        if (mulEn) begin v = aa * bb; r.isMul = 1'b1; end
        else begin r.wen = 1'b0; r.ill = 1'b1; end
      end
      OP_BR:  begin r.wen = 1'b0; r.taken = met; r.target = 32'(aa); end
      OP_BRL: begin v = pp; r.taken = met; r.target = 32'(aa); end
      OP_J:   begin r.wen = 1'b0; r.taken = 1'b1; r.target = 32'((pp + ii) & mask); end
      OP_JL:  begin v = pp; r.taken = 1'b1; r.target = 32'((pp + ii) & mask); end
      OP_LD:  v = bb + ii;
      OP_ST:  begin v = bb + ii; r.wen = 1'b0; end
      OP_LDR: v = pp + ii;
      OP_STR: begin v = pp + ii; r.wen = 1'b0; end
      default: begin r.wen = 1'b0; r.ill = 1'b1; end
    endcase
    r.result = 32'(v & mask);
    return r;
  endfunction

  // Model of the 32-bit unit: a held result, and a multiply countdown.
  bit   armed = 1'b0;
  bit   mValid, mBusy;
  int   mulLeft;
  expT  mHold, mMul;
  bit [4:0] mDest, mMulDest;

  always @(posedge clk) begin
    bit rdy;
    expT r;
    if (rst) begin
      armed = 1'b1;
      mValid = 1'b0;
      mBusy = 1'b0;
    end else if (armed) begin
      rdy = !flush && !mBusy && (!mValid || outReady);
      if (flush) begin
        mValid = 1'b0;
        mBusy = 1'b0;
      end else begin
        if (mValid && outReady) mValid = 1'b0;
        if (inValid && rdy) begin
          r = modelOp(int'(inOp), inCond, inA, inB, inImm, inPc, 32, 1'b1);
          if (r.isMul) begin
            mBusy = 1'b1;
            mulLeft = 32;
            mMul = r;
            mMulDest = inDest;
          end else begin
            mHold = r;
            mDest = inDest;
            mValid = 1'b1;
          end
        end else if (mBusy) begin
          mulLeft--;
          if (mulLeft == 0) begin
            mBusy = 1'b0;
            mHold = mMul;
            mDest = mMulDest;
            mValid = 1'b1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checkOutput("model.inReady", {31'd0, inReady},
                  {31'd0, !rst && !flush && !mBusy && (!mValid || outReady)});
      checkOutput("model.outValid", {31'd0, outValid}, {31'd0, mValid});
      if (mValid) begin
        checkOutput("model.result", outResult, mHold.result);
        checkOutput("model.dest", {27'd0, outDest}, {27'd0, mDest});
        checkOutput("model.wen", {31'd0, outWen}, {31'd0, mHold.wen});
        checkOutput("model.illegal", {31'd0, outIllegal}, {31'd0, mHold.ill});
        checkOutput("model.brTaken", {31'd0, brTaken}, {31'd0, mHold.taken});
        checkOutput("model.brTarget", brTarget, mHold.target);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setOp(input logic [4:0] op, input logic [2:0] cond, input logic [31:0] a, b, imm, pc,
                       input logic [4:0] dest);
    inOp = op; inCond = cond; inA = a; inB = b; inImm = imm; inPc = pc; inDest = dest;
  endtask

  task automatic setOp16(input logic [4:0] op, input logic [15:0] a, b);
    inOp16 = op; inA16 = a; inB16 = b;
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic applyStimulus();
    int op;
    rst = ($urandom_range(0, 299) == 0);
    flush = ($urandom_range(0, 39) == 0);
    inValid = ($urandom_range(0, 3) != 0);
    outReady = ($urandom_range(0, 9) < 7);
    op = $urandom_range(0, 31);
    if (op == OP_MUL && $urandom_range(0, 2) != 0) op = OP_XOR;
    setOp(5'(op), 3'($urandom_range(0, 7)), pickVal(), pickVal(), pickVal(), $urandom,
          5'($urandom_range(0, 31)));
    cycle();
  endtask

  initial begin
    int k, lowCnt, seen;
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    setOp(5'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0);
    inValid16 = 1'b0; outReady16 = 1'b1; flush16 = 1'b0;
    inCond16 = 3'd0; inImm16 = 16'd0; inPc16 = 16'd0; inDest16 = 5'd2;
    setOp16(5'd0, 16'd0, 16'd0);
    repeat (2) cycle();

    checkOutput("reset.inReady", {31'd0, inReady}, 32'd0);
    checkOutput("reset.outValid", {31'd0, outValid}, 32'd0);
    checkOutput("reset.result", outResult, 32'd0);
    checkOutput("reset.dest", {27'd0, outDest}, 32'd0);
    checkOutput("reset.wen", {31'd0, outWen}, 32'd0);
    checkOutput("reset.illegal", {31'd0, outIllegal}, 32'd0);
    checkOutput("reset.brTaken", {31'd0, brTaken}, 32'd0);
    checkOutput("reset.brTarget", brTarget, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset.inReadyAfter", {31'd0, inReady}, 32'd1);

    // Single-cycle ops issued back to back.
    inValid = 1'b1;
    setOp(OP_ADD, 3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd3);
    cycle();
    checkOutput("add.valid", {31'd0, outValid}, 32'd1);
    checkOutput("add.result", outResult, 32'h8000_0000);
    checkOutput("add.wen", {31'd0, outWen}, 32'd1);
    checkOutput("add.dest", {27'd0, outDest}, 32'd3);
    setOp(OP_ROR, 3'd0, 32'h0000_0001, 32'd1, 32'd0, 32'd0, 5'd4);
    cycle();
    checkOutput("ror1.result", outResult, 32'h8000_0000);
    setOp(OP_ROR, 3'd0, 32'h0000_0001, 32'd32, 32'd0, 32'd0, 5'd4);
    cycle();
    checkOutput("ror32.result", outResult, 32'h0000_0001);
    setOp(OP_BR, 3'd5, 32'h0000_0100, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0);
    cycle();
    checkOutput("brLtz.taken", {31'd0, brTaken}, 32'd1);
    checkOutput("brLtz.target", brTarget, 32'h0000_0100);
    checkOutput("brLtz.wen", {31'd0, outWen}, 32'd0);
    setOp(OP_BR, 3'd2, 32'h0000_0100, 32'd1, 32'd0, 32'd0, 5'd0);
    cycle();
    checkOutput("brEqz.taken", {31'd0, brTaken}, 32'd0);

    // Multiply latency and stall window.
    setOp(OP_MUL, 3'd0, 32'd7, 32'd6, 32'd0, 32'd0, 5'd9);
    cycle();
    inValid = 1'b0;
    k = 0; lowCnt = 0;
    while (outValid !== 1'b1 && k < 100) begin
      if (inReady === 1'b0) lowCnt++;
      cycle();
      k++;
    end
    checkOutput("mul.latency", k, 32'd32);
    checkOutput("mul.readyLow", lowCnt, 32'd32);
    checkOutput("mul.result", outResult, 32'd42);
    checkOutput("mul.dest", {27'd0, outDest}, 32'd9);
    cycle();

    // Multiply aborted by a flush partway through.
    inValid = 1'b1;
    setOp(OP_MUL, 3'd0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd10);
    cycle();
    inValid = 1'b0;
    repeat (9) cycle();
    flush = 1'b1;
    #1;
    checkOutput("flush.inReadyDuring", {31'd0, inReady}, 32'd0);
    cycle();
    flush = 1'b0;
    #1;
    checkOutput("flush.inReadyAfter", {31'd0, inReady}, 32'd1);
    checkOutput("flush.outValid", {31'd0, outValid}, 32'd0);
    seen = 0;
    repeat (40) begin
      cycle();
      if (outValid === 1'b1) seen++;
    end
    checkOutput("flush.noResult", seen, 32'd0);

    // Downstream stall with a second op waiting.
    outReady = 1'b0;
    inValid = 1'b1;
    setOp(OP_ADD, 3'd0, 32'd1, 32'd2, 32'd0, 32'd0, 5'd5);
    cycle();
    setOp(OP_ADD, 3'd0, 32'd10, 32'd20, 32'd0, 32'd0, 5'd6);
    repeat (5) begin
      cycle();
      checkOutput("stall.inReady", {31'd0, inReady}, 32'd0);
      checkOutput("stall.valid", {31'd0, outValid}, 32'd1);
      checkOutput("stall.result", outResult, 32'd3);
      checkOutput("stall.dest", {27'd0, outDest}, 32'd5);
    end
    outReady = 1'b1;
    cycle();
    inValid = 1'b0;
    checkOutput("stall.second", outResult, 32'd30);
    checkOutput("stall.secondDest", {27'd0, outDest}, 32'd6);
    cycle();
    checkOutput("stall.drained", {31'd0, outValid}, 32'd0);

    // 16-bit unit without the multiplier.
    inValid16 = 1'b1;
    setOp16(OP_MUL, 16'd7, 16'd6);
    cycle();
    checkOutput("x16mul.valid", {31'd0, outValid16}, 32'd1);
    checkOutput("x16mul.illegal", {31'd0, outIllegal16}, 32'd1);
    checkOutput("x16mul.wen", {31'd0, outWen16}, 32'd0);
    checkOutput("x16mul.result", {16'd0, outResult16}, 32'd0);
    setOp16(OP_ADD, 16'hFFFF, 16'd1);
    cycle();
    checkOutput("x16add.result", {16'd0, outResult16}, 32'd0);
    checkOutput("x16add.illegal", {31'd0, outIllegal16}, 32'd0);
    setOp16(OP_ROR, 16'd1, 16'd1);
    cycle();
    checkOutput("x16ror1.result", {16'd0, outResult16}, 32'h8000);
    setOp16(OP_ROR, 16'd1, 16'd16);
    cycle();
    checkOutput("x16ror16.result", {16'd0, outResult16}, 32'd1);
    setOp16(5'd31, 16'h1234, 16'h5678);
    cycle();
    checkOutput("x16undef.illegal", {31'd0, outIllegal16}, 32'd1);
    checkOutput("x16undef.result", {16'd0, outResult16}, 32'd0);
    inValid16 = 1'b0;

    for (int i = 0; i < 3000; i++) applyStimulus();

    rst = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
    repeat (40) cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/toy_exec_unit.md
TOY_EXEC_UNIT -- requirements
Module: toy_exec_unit

Interface
REQ-001 Parameter XW, default 32: datapath width in bits, minimum 8, power of two.
REQ-002 Parameter MUL_EN, default 1: 1 includes the iterative MUL op; 0 treats MUL as illegal.
REQ-003 Derived constant SHW = log2(XW): shift-amount width.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 IN_VALID  in  1  upstream presents an operation.
REQ-007 IN_READY  out  1  unit accepts the operation this cycle.
REQ-008 IN_OP  in  5  opcode, values defined in toy_exec_pkg.
REQ-009 IN_COND  in  3  branch condition for BR/BRL.
REQ-010 IN_A, IN_B, IN_IMM, IN_PC  in  XW each  operand A, operand B, sign-extended immediate, instruction address.
REQ-011 IN_DEST  in  5  destination register index.
REQ-012 FLUSH  in  1  discards in-flight and held work.
REQ-013 OUT_VALID  out  1  result held for downstream.
REQ-014 OUT_READY  in  1  downstream consumes the result.
REQ-015 OUT_RESULT  out  XW  result, return address, or memory address.
REQ-016 OUT_DEST  out  5  / OUT_WEN  out  1  / OUT_ILLEGAL  out  1  register index, writeback enable, illegal-op flag.
REQ-017 BR_TAKEN  out  1  / BR_TARGET  out  XW  redirect, qualified by OUT_VALID.

Function
REQ-018 Transfer on input when IN_VALID & IN_READY; on output when OUT_VALID & OUT_READY.
REQ-019 IN_READY = !RST & !FLUSH & state==IDLE & (!OUT_VALID | OUT_READY), combinational.
REQ-020 States: IDLE, MUL_BUSY; IDLE->MUL_BUSY on accepted MUL; MUL_BUSY->IDLE when the iteration count reaches XW.
REQ-021 Single-cycle ops: accepted at edge N, OUT_VALID=1 after edge N; back-to-back throughput one op per cycle when OUT_READY=1.
REQ-022 MUL: shift-add, one bit per cycle; accepted at edge N, OUT_VALID=1 after edge N+XW; low XW bits of product.
REQ-023 Ops: ADDI/ADD=A+B or B+IMM, SUB=A-B, NEG=-B, NOT=~B, AND/ANDI, OR/ORI, XOR, MOVI=IMM; arithmetic wraps modulo 2^XW.
REQ-024 LSR/ASR/SHL/ROR by B[SHW-1:0]; ROR by 0 returns A unchanged.
REQ-025 BR/BRL: BR_TARGET=A; BRL/JL result=IN_PC; J/JL target=IN_PC+IMM, BR_TAKEN=1.
REQ-026 Condition codes: 0 never, 1 always, 2 B==0, 3 B!=0, 4 B>=0 signed, 5 B<0 signed, 6-7 never.
REQ-027 LD/ST/LDR/STR result = address: LD/ST B+IMM, LDR/STR IN_PC+IMM.
REQ-028 OUT_WEN=1 for ALU ops, MUL, BRL, JL, LD, LDR; 0 for BR, J, ST, STR, illegal.
REQ-029 Undefined opcode (or MUL with MUL_EN=0): single-cycle, OUT_RESULT=0, OUT_WEN=0, OUT_ILLEGAL=1.
REQ-030 Outputs hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-031 FLUSH: next edge clears OUT_VALID, BR_TAKEN, aborts MUL, state->IDLE; concurrent IN_VALID ignored.
REQ-032 FLUSH and RST together: RST behaviour applies.

Reset
REQ-033 RST at edge: state IDLE, OUT_VALID/OUT_WEN/OUT_ILLEGAL/BR_TAKEN=0, OUT_RESULT/OUT_DEST/BR_TARGET=0, MUL counter 0.
REQ-034 RST mid-MUL discards the partial product; no result emitted.
REQ-035 IN_READY=0 while RST=1; 1 in first cycle after RST deasserts.

Structure
REQ-036 Package toy_exec_pkg holds opcode enum, condition-code constants, state enum.
REQ-037 Sub-module toy_iter_mul (parameter XW, start/done handshake, abort input) implements REQ-022.
REQ-038 Output register stage and FSM reside in toy_exec_unit.

Verification
REQ-039 XW=32, ADD A=0x7FFFFFFF B=1 -> OUT_RESULT=0x80000000, OUT_WEN=1, one cycle latency.
REQ-040 ROR A=0x00000001 B=1 -> 0x80000000; ROR B=32 -> 0x00000001.
REQ-041 MUL A=7 B=6 -> IN_READY low 32 cycles, OUT_RESULT=42 after edge N+32; FLUSH at cycle 10 -> no output, IN_READY=1 next cycle.
REQ-042 BR COND=5 B=0xFFFFFFFF A=0x100 -> BR_TAKEN=1 BR_TARGET=0x100; COND=2 B=1 -> BR_TAKEN=0.
REQ-043 OUT_READY=0 for 5 cycles with ops queued -> outputs stable, IN_READY=0, no op lost or duplicated.
REQ-044 XW=16, MUL_EN=0, MUL op -> OUT_ILLEGAL=1, OUT_WEN=0, OUT_RESULT=0.
